csr_regfile: RTL

- Control/status register file for the LoongArch32 core. It is the responder for the write-back stage's exception, ertn and CSR-write outputs.
- Accepts masked CSR writes and exception/ertn commits from WB. Serves combinational CSR reads to ID/EX.
- Returns the exception entry and ertn return PC to IF, and raises the interrupt-pending flag.
- Owns the constant timer (TID/TCFG/TVAL/TICLR) and the ESTAT interrupt-status bits.

---
 rtl/csr_regfile_pkg.sv | 55 +++++
 rtl/csr_timer.sv | 55 +++++
 rtl/csr_regfile.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/csr_regfile_pkg.sv
// Shared definitions for the LoongArch32 CSR register file:
// CSR numbers, software-writable field masks, field bit positions,
// the exception codes that latch BADV, and the masked-write helper.
package csr_regfile_pkg;

  typedef logic [13:0] csr_num_t;

  // CSR numbers
  localparam csr_num_t CSR_CRMD   = 14'h0000;
  localparam csr_num_t CSR_PRMD   = 14'h0001;
  localparam csr_num_t CSR_ECFG   = 14'h0004;
  localparam csr_num_t CSR_ESTAT  = 14'h0005;
  localparam csr_num_t CSR_ERA    = 14'h0006;
  localparam csr_num_t CSR_BADV   = 14'h0007;
  localparam csr_num_t CSR_EENTRY = 14'h000C;
  localparam csr_num_t CSR_SAVE0  = 14'h0030;
  localparam csr_num_t CSR_SAVE1  = 14'h0031;
  localparam csr_num_t CSR_SAVE2  = 14'h0032;
  localparam csr_num_t CSR_SAVE3  = 14'h0033;
  localparam csr_num_t CSR_TID    = 14'h0040;
  localparam csr_num_t CSR_TCFG   = 14'h0041;
  localparam csr_num_t CSR_TVAL   = 14'h0042;
  localparam csr_num_t CSR_TICLR  = 14'h0044;

  // Software-writable bits of each CSR (everything else reads 0)
  localparam logic [31:0] CRMD_WMASK     = 32'h0000_01FF;
  localparam logic [31:0] PRMD_WMASK     = 32'h0000_0007;
  localparam logic [31:0] ECFG_WMASK     = 32'h0000_1BFF;
  localparam logic [31:0] ESTAT_SW_WMASK = 32'h0000_0003;
  localparam logic [31:0] EENTRY_WMASK   = 32'hFFFF_FFC0;
  localparam logic [31:0] FULL_WMASK     = 32'hFFFF_FFFF;

  // Field bit positions
  localparam int CRMD_IE         = 2;
  localparam int ESTAT_ECODE_LSB = 16;
  localparam int ESTAT_ESUB_LSB  = 22;
  localparam int IS_HW_LSB       = 2;
  localparam int IS_TI           = 11;
  localparam int IS_IPI          = 12;
  localparam int TCFG_EN         = 0;
  localparam int TCFG_PERIODIC   = 1;

  // Exception codes that capture the faulting address into BADV
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;

  // Masked write restricted to the register's writable field bits
  function automatic logic [31:0] masked_write(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [31:0] wmask,
                                               input logic [31:0] field);
    return (old & ~(wmask & field)) | (wdata & wmask & field);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// Constant timer: owns TCFG and TVAL.
// Ports:
//   clk, resetn      - clock, asynchronous active-low reset
//   tcfg_we          - TCFG write accepted this cycle
//   tcfg_new         - TCFG value after the masked write
//   tcfg_q, tval_q   - current TCFG / TVAL for CSR reads
//   timer_fire       - one-cycle pulse while En=1 and TVAL==0
module csr_timer
  import csr_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        tcfg_we,
  input  logic [31:0] tcfg_new,
  output logic [31:0] tcfg_q,
  output logic [31:0] tval_q,
  output logic        timer_fire
);

  logic [31:0] tcfg_d;
  logic [31:0] tval_d;

  // Fire is a function of registered state so ESTAT.IS[11] sets the
  // cycle after TVAL reads 0.
  assign timer_fire = tcfg_q[TCFG_EN] && (tval_q == 32'h0);

  always_comb begin
    tcfg_d = tcfg_q;
    tval_d = tval_q;
    if (tcfg_we) begin
      tcfg_d = tcfg_new;
    end
    if (tcfg_we && tcfg_new[TCFG_EN]) begin
      tval_d = {tcfg_new[31:2], 2'b00};
    end else if (tcfg_q[TCFG_EN] && (tval_q != 32'hFFFF_FFFF)) begin
      // One-shot mode wraps 0 -> FFFF_FFFF through the decrement and then stops
      if ((tval_q == 32'h0) && tcfg_q[TCFG_PERIODIC]) begin
        tval_d = {tcfg_q[31:2], 2'b00};
      end else begin
        tval_d = tval_q - 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcfg_q <= 32'h0;
      tval_q <= 32'hFFFF_FFFF;
    end else begin
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
    end
  end

endmodule

// File: rtl/csr_regfile.sv
// LoongArch32 control/status register file.
// Ports:
//   clk, resetn                 - clock, asynchronous active-low reset
//   csr_rnum / csr_rvalue       - combinational CSR read
//   csr_we/wnum/wdata/wmask     - masked CSR write from WB
//   wb_ex, wb_ertn_flush        - exception / ertn commit from WB
//   wb_pc, wb_badv, wb_ecode,
//   wb_esubcode                 - exception commit information
//   hw_int_in, ipi_int_in       - level interrupt inputs
//   ex_entry, ertn_entry        - redirect targets for IF
//   has_int                     - enabled interrupt pending
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [13:0] csr_rnum,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [13:0] csr_wnum,
  input  logic [31:0] csr_wdata,
  input  logic [31:0] csr_wmask,
  input  logic        wb_ex,
  input  logic        wb_ertn_flush,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_badv,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry,
  output logic        has_int
);

  logic [31:0] crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d;
  logic [31:0] estat_q, estat_d, era_q, era_d, badv_q, badv_d;
  logic [31:0] eentry_q, eentry_d, tid_q, tid_d;
  logic [31:0] save_q [4];
  logic [31:0] save_d [4];
  logic [31:0] tcfg_q, tval_q;
  logic        timer_fire;
  logic        sw_we, tcfg_we, ticlr_clr;

  // Commits from WB take the whole cycle; software writes are dropped.
  assign sw_we     = csr_we && !wb_ex && !wb_ertn_flush;
  assign tcfg_we   = sw_we && (csr_wnum == CSR_TCFG);
  assign ticlr_clr = sw_we && (csr_wnum == CSR_TICLR) && csr_wdata[0] && csr_wmask[0];

  csr_timer u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .tcfg_we    (tcfg_we),
    .tcfg_new   (masked_write(tcfg_q, csr_wdata, csr_wmask, FULL_WMASK)),
    .tcfg_q     (tcfg_q),
    .tval_q     (tval_q),
    .timer_fire (timer_fire)
  );

  always_comb begin
    crmd_d   = crmd_q;
    prmd_d   = prmd_q;
    ecfg_d   = ecfg_q;
    estat_d  = estat_q;
    era_d    = era_q;
    badv_d   = badv_q;
    eentry_d = eentry_q;
    tid_d    = tid_q;
    for (int i = 0; i < 4; i++) save_d[i] = save_q[i];

    if (wb_ex) begin
      prmd_d[2:0] = crmd_q[2:0];
      crmd_d[2:0] = 3'b000;
      era_d       = wb_pc;
      estat_d[ESTAT_ECODE_LSB +: 6] = wb_ecode;
      estat_d[ESTAT_ESUB_LSB +: 9]  = wb_esubcode;
      if ((wb_ecode == ECODE_ADEF) || (wb_ecode == ECODE_ALE)) begin
        badv_d = wb_badv;
      end
    end else if (wb_ertn_flush) begin
      crmd_d[2:0] = prmd_q[2:0];
    end else if (csr_we) begin
      case (csr_wnum)
        CSR_CRMD:   crmd_d   = masked_write(crmd_q, csr_wdata, csr_wmask, CRMD_WMASK);
        CSR_PRMD:   prmd_d   = masked_write(prmd_q, csr_wdata, csr_wmask, PRMD_WMASK);
        CSR_ECFG:   ecfg_d   = masked_write(ecfg_q, csr_wdata, csr_wmask, ECFG_WMASK);
        CSR_ESTAT:  estat_d  = masked_write(estat_q, csr_wdata, csr_wmask, ESTAT_SW_WMASK);
        CSR_ERA:    era_d    = masked_write(era_q, csr_wdata, csr_wmask, FULL_WMASK);
        CSR_BADV:   badv_d   = masked_write(badv_q, csr_wdata, csr_wmask, FULL_WMASK);
        CSR_EENTRY: eentry_d = masked_write(eentry_q, csr_wdata, csr_wmask, EENTRY_WMASK);
        CSR_SAVE0:  save_d[0] = masked_write(save_q[0], csr_wdata, csr_wmask, FULL_WMASK);
        CSR_SAVE1:  save_d[1] = masked_write(save_q[1], csr_wdata, csr_wmask, FULL_WMASK);
        CSR_SAVE2:  save_d[2] = masked_write(save_q[2], csr_wdata, csr_wmask, FULL_WMASK);
        CSR_SAVE3:  save_d[3] = masked_write(save_q[3], csr_wdata, csr_wmask, FULL_WMASK);
        CSR_TID:    tid_d    = masked_write(tid_q, csr_wdata, csr_wmask, FULL_WMASK);
        default: ;
      endcase
    end

    // Interrupt status is sampled every cycle regardless of commits.
    estat_d[IS_HW_LSB +: 8] = hw_int_in;
    estat_d[IS_IPI]         = ipi_int_in;
    // Timer set wins over a coincident TICLR clear.
    if (timer_fire) begin
      estat_d[IS_TI] = 1'b1;
    end else if (ticlr_clr) begin
      estat_d[IS_TI] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd_q   <= 32'h0000_0008;
      prmd_q   <= 32'h0;
      ecfg_q   <= 32'h0;
      estat_q  <= 32'h0;
      era_q    <= 32'h0;
      badv_q   <= 32'h0;
      eentry_q <= 32'h0;
      tid_q    <= TID_RESET;
      for (int i = 0; i < 4; i++) save_q[i] <= 32'h0;
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      ecfg_q   <= ecfg_d;
      estat_q  <= estat_d;
      era_q    <= era_d;
      badv_q   <= badv_d;
      eentry_q <= eentry_d;
      tid_q    <= tid_d;
      for (int i = 0; i < 4; i++) save_q[i] <= save_d[i];
    end
  end

  always_comb begin
    case (csr_rnum)
      CSR_CRMD:   csr_rvalue = crmd_q;
      CSR_PRMD:   csr_rvalue = prmd_q;
      CSR_ECFG:   csr_rvalue = ecfg_q;
      CSR_ESTAT:  csr_rvalue = estat_q;
      CSR_ERA:    csr_rvalue = era_q;
      CSR_BADV:   csr_rvalue = badv_q;
      CSR_EENTRY: csr_rvalue = eentry_q;
      CSR_SAVE0:  csr_rvalue = save_q[0];
      CSR_SAVE1:  csr_rvalue = save_q[1];
      CSR_SAVE2:  csr_rvalue = save_q[2];
      CSR_SAVE3:  csr_rvalue = save_q[3];
      CSR_TID:    csr_rvalue = tid_q;
      CSR_TCFG:   csr_rvalue = tcfg_q;
      CSR_TVAL:   csr_rvalue = tval_q;
      default:    csr_rvalue = 32'h0;
    endcase
  end

  assign ex_entry   = {eentry_q[31:6], 6'b0};
  assign ertn_entry = era_q;
  assign has_int    = crmd_q[CRMD_IE] && |(estat_q[12:0] & ecfg_q[12:0]);

endmodule
